// File: rtl/tmr_alu_fault_monitor_if.sv
// Bus between the TMR ALU voter and the fault monitor: match flags and voted
// result in, classification, statistics and health status out.
interface tmr_alu_fault_monitor_if #(
  parameter int unsigned N     = 64,
  parameter int unsigned CNT_W = 16
);
  logic             valid;
  logic             alu1_alu2_match;
  logic             alu1_alu3_match;
  logic             alu2_alu3_match;
  logic [N-1:0]     voted_result;
  logic             clear;

  logic [2:0]       event_code;
  logic [CNT_W-1:0] err_cnt1;
  logic [CNT_W-1:0] err_cnt2;
  logic [CNT_W-1:0] err_cnt3;
  logic [CNT_W-1:0] uncorr_cnt;
  logic [2:0]       unit_failed;
  logic [1:0]       health;
  logic             irq;
  logic [N-1:0]     first_err_result;
  logic [31:0]      first_err_time;

  // Voter side: drives flags and clear, observes monitor status
  modport master (
    output valid, alu1_alu2_match, alu1_alu3_match, alu2_alu3_match,
           voted_result, clear,
    input  event_code, err_cnt1, err_cnt2, err_cnt3, uncorr_cnt,
           unit_failed, health, irq, first_err_result, first_err_time
  );

  // Monitor side
  modport slave (
    input  valid, alu1_alu2_match, alu1_alu3_match, alu2_alu3_match,
           voted_result, clear,
    output event_code, err_cnt1, err_cnt2, err_cnt3, uncorr_cnt,
           unit_failed, health, irq, first_err_result, first_err_time
  );
endinterface

// File: rtl/tmr_alu_fault_monitor.sv
// TMR ALU fault monitor: classifies voter match flags, keeps saturating
// per-unit statistics, declares persistently disagreeing units failed and
// runs an OK/DEGRADED/FAILED health FSM with a sticky interrupt.
// Optional first-error capture is enabled by defining TMR_MON_CAPTURE_EN.
module tmr_alu_fault_monitor #(
  parameter int unsigned N          = 64,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PERSIST_TH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  tmr_alu_fault_monitor_if.slave bus
);

  localparam int unsigned        RUN_W   = 8;
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic [RUN_W-1:0]   RUN_MAX = '1;
  localparam logic [RUN_W-1:0]   RUN_TH  = RUN_W'(PERSIST_TH);

  typedef enum logic [2:0] {
    EV_CLEAN  = 3'd0,
    EV_ALU1   = 3'd1,
    EV_ALU2   = 3'd2,
    EV_ALU3   = 3'd3,
    EV_UNCORR = 3'd4
  } event_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_DEGRADED = 2'd1,
    ST_FAILED   = 2'd2
  } health_e;

  event_e           w_class;
  logic             w_ev;
  logic [2:0]       w_blame;
  logic [2:0]       w_agree;
  logic             w_uncorr_ev;
  logic [RUN_W-1:0] w_run_nxt [3];
  logic [2:0]       w_fail_nxt;
  logic [1:0]       w_fail_cnt;
  health_e          w_health_nxt;

  event_e           r_event_code;
  logic [CNT_W-1:0] r_err [3];
  logic [CNT_W-1:0] r_uncorr;
  logic [RUN_W-1:0] r_run [3];
  logic [2:0]       r_fail;
  health_e          r_health;
  logic             r_irq;

  // Classify the pairwise match flags; any two-flag pattern is non-transitive
  always_comb begin
    w_class = EV_UNCORR;
    unique case ({bus.alu1_alu2_match, bus.alu1_alu3_match, bus.alu2_alu3_match})
      3'b111:  w_class = EV_CLEAN;
      3'b001:  w_class = EV_ALU1;
      3'b010:  w_class = EV_ALU2;
      3'b100:  w_class = EV_ALU3;
      default: w_class = EV_UNCORR;
    endcase
  end

  // A clear in the same cycle discards the event
  assign w_ev        = bus.valid & ~bus.clear;
  assign w_uncorr_ev = w_ev && (w_class == EV_UNCORR);
  assign w_blame[0]  = w_ev && (w_class == EV_ALU1);
  assign w_blame[1]  = w_ev && (w_class == EV_ALU2);
  assign w_blame[2]  = w_ev && (w_class == EV_ALU3);
  assign w_agree     = {3{w_ev && (w_class != EV_UNCORR)}} & ~w_blame;

  // Consecutive-blame run counters and the failure flags they feed
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_run_nxt[k] = r_run[k];
      if (w_blame[k]) begin
        w_run_nxt[k] = (r_run[k] == RUN_MAX) ? r_run[k] : r_run[k] + RUN_W'(1);
      end else if (w_agree[k]) begin
        w_run_nxt[k] = '0;
      end
    end
    for (int k = 0; k < 3; k++) begin
      w_fail_nxt[k] = r_fail[k] | (w_blame[k] && (w_run_nxt[k] >= RUN_TH));
    end
    w_fail_cnt = 2'($countones(w_fail_nxt));
  end

  // Health FSM next state, judged on post-update failure flags
  always_comb begin
    w_health_nxt = r_health;
    if (bus.clear) begin
      w_health_nxt = ST_OK;
    end else begin
      unique case (r_health)
        ST_OK: begin
          if ((w_fail_cnt >= 2'd2) || w_uncorr_ev) begin
            w_health_nxt = ST_FAILED;
          end else if (w_fail_cnt == 2'd1) begin
            w_health_nxt = ST_DEGRADED;
          end
        end
        ST_DEGRADED: begin
          if ((w_fail_cnt >= 2'd2) || w_uncorr_ev) begin
            w_health_nxt = ST_FAILED;
          end
        end
        ST_FAILED: w_health_nxt = ST_FAILED;
        default:   w_health_nxt = ST_OK;
      endcase
    end
  end

  // Health state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_health <= ST_OK;
    end else begin
      r_health <= w_health_nxt;
    end
  end

  // Event code, statistics, run counters, failure flags and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_event_code <= EV_CLEAN;
      r_uncorr     <= '0;
      r_fail       <= '0;
      r_irq        <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        r_err[k] <= '0;
        r_run[k] <= '0;
      end
    end else if (bus.clear) begin
      r_event_code <= EV_CLEAN;
      r_uncorr     <= '0;
      r_fail       <= '0;
      r_irq        <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        r_err[k] <= '0;
        r_run[k] <= '0;
      end
    end else begin
      r_event_code <= w_ev ? w_class : EV_CLEAN;
      if (w_uncorr_ev && (r_uncorr != CNT_MAX)) begin
        r_uncorr <= r_uncorr + CNT_W'(1);
      end
      for (int k = 0; k < 3; k++) begin
        if (w_blame[k] && (r_err[k] != CNT_MAX)) begin
          r_err[k] <= r_err[k] + CNT_W'(1);
        end
        r_run[k] <= w_run_nxt[k];
      end
      r_fail <= w_fail_nxt;
      r_irq  <= r_irq | (w_health_nxt != r_health);
    end
  end

  assign bus.event_code  = r_event_code;
  assign bus.err_cnt1    = r_err[0];
  assign bus.err_cnt2    = r_err[1];
  assign bus.err_cnt3    = r_err[2];
  assign bus.uncorr_cnt  = r_uncorr;
  assign bus.unit_failed = r_fail;
  assign bus.health      = r_health;
  assign bus.irq         = r_irq;

`ifdef TMR_MON_CAPTURE_EN
  logic [31:0]  r_cyc;
  logic         r_cap_done;
  logic [N-1:0] r_cap_result;
  logic [31:0]  r_cap_time;

  // Free-running cycle counter and one-shot capture of the first error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cyc        <= '0;
      r_cap_done   <= 1'b0;
      r_cap_result <= '0;
      r_cap_time   <= '0;
    end else begin
      r_cyc <= r_cyc + 32'd1;
      if (bus.clear) begin
        r_cap_done   <= 1'b0;
        r_cap_result <= '0;
        r_cap_time   <= '0;
      end else if (w_ev && (w_class != EV_CLEAN) && !r_cap_done) begin
        r_cap_done   <= 1'b1;
        r_cap_result <= bus.voted_result;
        r_cap_time   <= r_cyc;
      end
    end
  end

  assign bus.first_err_result = r_cap_result;
  assign bus.first_err_time   = r_cap_time;
`else
  // Voted result is only consumed by the capture logic
  logic [N-1:0] w_unused_voted;
  assign w_unused_voted       = bus.voted_result;
  assign bus.first_err_result = '0;
  assign bus.first_err_time   = '0;
`endif

endmodule

// File: tb/tb_tmr_alu_fault_monitor.sv
// Directed plus randomized bench for tmr_alu_fault_monitor with a
// behavioural reference model of classification, statistics and health.
module tb_tmr_alu_fault_monitor;

  localparam int unsigned N     = 64;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned PTH   = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic reset_n;

  tmr_alu_fault_monitor_if #(.N(N), .CNT_W(CNT_W)) bus ();

  tmr_alu_fault_monitor #(.N(N), .CNT_W(CNT_W), .PERSIST_TH(PTH)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_code;
  int          m_err [3];
  int          m_unc;
  int          m_run [3];
  bit [2:0]    m_fail;
  int          m_health;
  bit          m_irq;
  int unsigned m_cyc;
  bit          m_cap_done;
  logic [63:0] m_cap_res;
  logic [31:0] m_cap_time;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_code = 0; m_unc = 0; m_fail = '0; m_health = 0; m_irq = 0;
    for (int k = 0; k < 3; k++) begin m_err[k] = 0; m_run[k] = 0; end
    m_cyc = 0; m_cap_done = 0; m_cap_res = '0; m_cap_time = '0;
  endfunction

  // Which unit (1..3) is the odd one out, 0 if all agree, 4 otherwise
  function automatic int classify(input bit a12, input bit a13, input bit a23);
    int n;
    n = int'(a12) + int'(a13) + int'(a23);
    if (n == 3) return 0;
    if (n == 1) return a23 ? 1 : (a13 ? 2 : 3);
    return 4;
  endfunction

  function automatic void model_step(input bit v, input bit a12, input bit a13, input bit a23,
                                     input bit clr, input logic [63:0] vr);
    int c, nf, h;
    if (clr) begin
      m_code = 0; m_unc = 0; m_fail = '0; m_health = 0; m_irq = 0;
      for (int k = 0; k < 3; k++) begin m_err[k] = 0; m_run[k] = 0; end
      m_cap_done = 0; m_cap_res = '0; m_cap_time = '0;
    end else if (!v) begin
      m_code = 0;
    end else begin
      c = classify(a12, a13, a23);
      m_code = c;
      if (c == 4) begin
        if (m_unc < CMAX) m_unc++;
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (c == k + 1) begin
            if (m_err[k] < CMAX) m_err[k]++;
            if (m_run[k] < 255) m_run[k]++;
            if (m_run[k] >= PTH) m_fail[k] = 1'b1;
          end else begin
            m_run[k] = 0;
          end
        end
      end
      if (c != 0 && !m_cap_done) begin
        m_cap_done = 1; m_cap_res = vr; m_cap_time = m_cyc;
      end
      nf = int'(m_fail[0]) + int'(m_fail[1]) + int'(m_fail[2]);
      h = m_health;
      if (h != 2) begin
        if (nf >= 2 || c == 4) h = 2;
        else if (nf == 1) h = 1;
      end
      if (h != m_health) m_irq = 1;
      m_health = h;
    end
    m_cyc++;
  endfunction

  task automatic check_all(input string ph);
    chk({ph, ":event_code"}, 64'(bus.event_code), 64'(m_code));
    chk({ph, ":err_cnt1"}, 64'(bus.err_cnt1), 64'(m_err[0]));
    chk({ph, ":err_cnt2"}, 64'(bus.err_cnt2), 64'(m_err[1]));
    chk({ph, ":err_cnt3"}, 64'(bus.err_cnt3), 64'(m_err[2]));
    chk({ph, ":uncorr_cnt"}, 64'(bus.uncorr_cnt), 64'(m_unc));
    chk({ph, ":unit_failed"}, 64'(bus.unit_failed), 64'(m_fail));
    chk({ph, ":health"}, 64'(bus.health), 64'(m_health));
    chk({ph, ":irq"}, 64'(bus.irq), 64'(m_irq));
`ifdef TMR_MON_CAPTURE_EN
    chk({ph, ":first_err_result"}, bus.first_err_result, m_cap_res);
    chk({ph, ":first_err_time"}, 64'(bus.first_err_time), 64'(m_cap_time));
`else
    chk({ph, ":first_err_result"}, bus.first_err_result, 64'd0);
    chk({ph, ":first_err_time"}, 64'(bus.first_err_time), 64'd0);
`endif
  endtask

  task automatic check_zero(input string ph);
    chk({ph, ":event_code"}, 64'(bus.event_code), 64'd0);
    chk({ph, ":err_cnt1"}, 64'(bus.err_cnt1), 64'd0);
    chk({ph, ":err_cnt2"}, 64'(bus.err_cnt2), 64'd0);
    chk({ph, ":err_cnt3"}, 64'(bus.err_cnt3), 64'd0);
    chk({ph, ":uncorr_cnt"}, 64'(bus.uncorr_cnt), 64'd0);
    chk({ph, ":unit_failed"}, 64'(bus.unit_failed), 64'd0);
    chk({ph, ":health"}, 64'(bus.health), 64'd0);
    chk({ph, ":irq"}, 64'(bus.irq), 64'd0);
    chk({ph, ":first_err_result"}, bus.first_err_result, 64'd0);
    chk({ph, ":first_err_time"}, 64'(bus.first_err_time), 64'd0);
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare
  task automatic step(input string ph, input bit v, input bit a12, input bit a13,
                      input bit a23, input bit clr, input logic [63:0] vr);
    bus.valid = v; bus.alu1_alu2_match = a12; bus.alu1_alu3_match = a13;
    bus.alu2_alu3_match = a23; bus.clear = clr; bus.voted_result = vr;
    @(posedge clk);
    #1;
    model_step(v, a12, a13, a23, clr, vr);
    check_all(ph);
  endtask

  task automatic clean(input string ph);
    step(ph, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
  endtask

  task automatic blame(input string ph, input int u, input logic [63:0] vr);
    step(ph, 1'b1, u == 3, u == 2, u == 1, 1'b0, vr);
  endtask

  task automatic do_clear(input string ph);
    step(ph, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
  endtask

  // Asynchronous reset: outputs must drop before any clock edge
  task automatic do_reset(input string ph);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero(ph);
    bus.valid = 1'b0; bus.clear = 1'b0;
    bus.alu1_alu2_match = 1'b0; bus.alu1_alu3_match = 1'b0; bus.alu2_alu3_match = 1'b0;
    bus.voted_result = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int r, u, last_u;
    reset_n = 1'b0;
    bus.valid = 1'b0; bus.clear = 1'b0;
    bus.alu1_alu2_match = 1'b0; bus.alu1_alu3_match = 1'b0; bus.alu2_alu3_match = 1'b0;
    bus.voted_result = '0;
    do_reset("reset");

    // First error at cycle 7, second at cycle 9: capture holds the first
    for (int i = 0; i < 7; i++) clean("cap_pre");
    blame("cap_first", 1, 64'hDEAD_BEEF);
    clean("cap_mid");
    blame("cap_second", 2, 64'h1234_5678_9ABC_DEF0);
    clean("cap_post");
`ifdef TMR_MON_CAPTURE_EN
    chk("cap_result_const", bus.first_err_result, 64'hDEAD_BEEF);
    chk("cap_time_const", 64'(bus.first_err_time), 64'd7);
`else
    chk("cap_result_const", bus.first_err_result, 64'd0);
    chk("cap_time_const", 64'(bus.first_err_time), 64'd0);
`endif
    do_clear("clear1");

    // Ten clean operations
    for (int i = 0; i < 10; i++) clean("tp_clean");
    chk("tp_clean_health", 64'(bus.health), 64'd0);
    chk("tp_clean_irq", 64'(bus.irq), 64'd0);

    // Four consecutive ALU1 blames declare ALU1 failed
    for (int i = 0; i < 3; i++) blame("tp_alu1", 1, 64'h0);
    chk("tp_alu1_not_yet", 64'(bus.unit_failed), 64'd0);
    blame("tp_alu1", 1, 64'h0);
    chk("tp_alu1_err", 64'(bus.err_cnt1), 64'd4);
    chk("tp_alu1_failed", 64'(bus.unit_failed), 64'b001);
    chk("tp_alu1_health", 64'(bus.health), 64'd1);
    chk("tp_alu1_irq", 64'(bus.irq), 64'd1);

    // Idle cycle with garbage flags reports nothing
    step("idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("idle_code", 64'(bus.event_code), 64'd0);

    // ALU3 fails too, then an uncorrectable event
    for (int i = 0; i < 4; i++) blame("tp_alu3", 3, 64'h0);
    chk("tp_alu3_failed", 64'(bus.unit_failed), 64'b101);
    chk("tp_alu3_health", 64'(bus.health), 64'd2);
    step("tp_uncorr", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("tp_uncorr_code", 64'(bus.event_code), 64'd4);
    chk("tp_uncorr_cnt", 64'(bus.uncorr_cnt), 64'd1);
    chk("tp_uncorr_health", 64'(bus.health), 64'd2);
    do_clear("clear2");

    // A clean event breaks the run
    for (int i = 0; i < 3; i++) blame("tp_run", 1, 64'h0);
    clean("tp_run_break");
    for (int i = 0; i < 3; i++) blame("tp_run", 1, 64'h0);
    chk("tp_run_err", 64'(bus.err_cnt1), 64'd6);
    chk("tp_run_failed", 64'(bus.unit_failed), 64'd0);
    chk("tp_run_health", 64'(bus.health), 64'd0);
    do_clear("clear3");

    // Uncorrectable events leave runs untouched
    for (int i = 0; i < 3; i++) blame("hold_run", 2, 64'h0);
    step("hold_run_u", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    blame("hold_run", 2, 64'h0);
    chk("hold_run_failed", 64'(bus.unit_failed), 64'b010);

    // Clear wins over a simultaneous uncorrectable event
    step("clear_win", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF);
    chk("clear_win_unc", 64'(bus.uncorr_cnt), 64'd0);
    chk("clear_win_health", 64'(bus.health), 64'd0);
    chk("clear_win_irq", 64'(bus.irq), 64'd0);

    // Saturation of per-unit and uncorrectable counters
    for (int i = 0; i < 40; i++) blame("sat_err", (i % 2) + 1, 64'h0);
    chk("sat_err1", 64'(bus.err_cnt1), 64'(CMAX));
    chk("sat_err2", 64'(bus.err_cnt2), 64'(CMAX));
    for (int i = 0; i < 20; i++) step("sat_unc", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    chk("sat_unc", 64'(bus.uncorr_cnt), 64'(CMAX));
    do_clear("clear4");

    // Randomized traffic against the model
    last_u = 1;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55) begin
        clean("rnd");
      end else if (r < 85) begin
        u = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : last_u;
        last_u = u;
        blame("rnd", u, {$urandom, $urandom});
      end else if (r < 89) begin
        u = int'($urandom_range(0, 2));
        step("rnd", 1'b1, u != 0, u != 1, u != 2, 1'b0, {$urandom, $urandom});
      end else if (r < 92) begin
        step("rnd", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {$urandom, $urandom});
      end else if (r < 97) begin
        step("rnd", 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 64'h0);
      end else begin
        step("rnd", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 64'h0);
      end
    end

    // Reset in the middle of activity
    blame("pre_reset", 1, 64'h55);
    blame("pre_reset", 1, 64'h66);
    do_reset("mid_reset");
    clean("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
